// File: rtl/accum_scheduler.sv
// Accumulation scheduler: streams partial sums into a two-buffer accumulator memory and
// drains completed results through two in-order holding slots.
module accum_scheduler #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_tiles,
    input  logic [CNT_W-1:0] cfg_results,
    input  logic             psum_valid,
    output logic             psum_ready,
    input  logic [15:0]      psum_col0,
    input  logic [15:0]      psum_col1,
    output logic             acc_enable,
    output logic             acc_mode,
    output logic             acc_buffer_select,
    output logic [15:0]      acc_in_col0,
    output logic [15:0]      acc_in_col1,
    input  logic             acc_valid_out,
    input  logic [31:0]      acc_out_col0,
    input  logic [31:0]      acc_out_col1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_col0,
    output logic [31:0]      res_col1,
    output logic             res_buf,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tiles_q, results_q;
    logic [CNT_W-1:0] tile_cnt_q, issued_cnt_q, drained_cnt_q;
    logic             fill_buf_q, rd_ptr_q;
    logic [1:0]       full_q, pending_q;
    logic [31:0]      hold0_q [2];
    logic [31:0]      hold1_q [2];
    logic             err_q;

    logic             xfer, last, drain, capture, cap_slot, job_start;
    logic [CNT_W-1:0] issued_inc, drained_inc;

    always_comb begin
        psum_ready        = (state_q == StRun) && !full_q[fill_buf_q] && !pending_q[fill_buf_q];
        xfer              = psum_valid && psum_ready;
        last              = xfer && (tile_cnt_q == tiles_q - CNT_W'(1));
        res_valid         = full_q[rd_ptr_q];
        drain             = res_valid && res_ready;
        // At most one slot is ever pending, so the pending bit of slot 1 names it.
        capture           = |pending_q;
        cap_slot          = pending_q[1];
        job_start         = (state_q == StIdle) && start;
        issued_inc        = issued_cnt_q + CNT_W'(1);
        drained_inc       = drained_cnt_q + CNT_W'(1);

        acc_enable        = xfer;
        acc_mode          = (tile_cnt_q != '0);
        acc_buffer_select = fill_buf_q;
        acc_in_col0       = psum_col0;
        acc_in_col1       = psum_col1;
        res_col0          = hold0_q[rd_ptr_q];
        res_col1          = hold1_q[rd_ptr_q];
        res_buf           = rd_ptr_q;
        busy              = (state_q == StRun) || (state_q == StDrain);
        done              = (state_q == StDone);
        err               = err_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = (cfg_results == '0) ? StDone : StRun;
            StRun:   if (last && (issued_inc == results_q)) state_d = StDrain;
            StDrain: if (drain && (drained_inc == results_q)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            tiles_q       <= '0;
            results_q     <= '0;
            tile_cnt_q    <= '0;
            issued_cnt_q  <= '0;
            drained_cnt_q <= '0;
            fill_buf_q    <= 1'b0;
            rd_ptr_q      <= 1'b0;
            full_q        <= '0;
            pending_q     <= '0;
            hold0_q[0]    <= '0;
            hold0_q[1]    <= '0;
            hold1_q[0]    <= '0;
            hold1_q[1]    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (job_start) begin
                tiles_q       <= (cfg_tiles == '0) ? CNT_W'(1) : cfg_tiles;
                results_q     <= cfg_results;
                tile_cnt_q    <= '0;
                issued_cnt_q  <= '0;
                drained_cnt_q <= '0;
                fill_buf_q    <= 1'b0;
                rd_ptr_q      <= 1'b0;
                full_q        <= '0;
                pending_q     <= '0;
            end else begin
                if (xfer) begin
                    if (last) begin
                        tile_cnt_q            <= '0;
                        pending_q[fill_buf_q] <= 1'b1;
                        fill_buf_q            <= ~fill_buf_q;
                        issued_cnt_q          <= issued_inc;
                    end else begin
                        tile_cnt_q <= tile_cnt_q + CNT_W'(1);
                    end
                end
                // Memory output belongs to the previous cycle's last transfer.
                if (capture) begin
                    hold0_q[cap_slot]   <= acc_out_col0;
                    hold1_q[cap_slot]   <= acc_out_col1;
                    full_q[cap_slot]    <= 1'b1;
                    pending_q[cap_slot] <= 1'b0;
                    if (!acc_valid_out) err_q <= 1'b1;
                end
                if (drain) begin
                    full_q[rd_ptr_q] <= 1'b0;
                    rd_ptr_q         <= ~rd_ptr_q;
                    drained_cnt_q    <= drained_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_scheduler.sv
// Directed bench for accum_scheduler with a behavioural two-buffer accumulator memory.
module tb_accum_scheduler;

    logic        clk = 1'b0;
    logic        reset, start, psum_valid, psum_ready;
    logic [7:0]  cfg_tiles, cfg_results;
    logic [15:0] psum_col0, psum_col1, acc_in_col0, acc_in_col1;
    logic        acc_enable, acc_mode, acc_buffer_select, acc_valid_out;
    logic [31:0] acc_out_col0, acc_out_col1, res_col0, res_col1;
    logic        res_valid, res_ready, res_buf, busy, done, err;
    logic        kill_valid;
    logic [31:0] mem0 [2];
    logic [31:0] mem1 [2];

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [7:0]       tiles;
        logic [7:0]       results;
        logic [3:0]       n;
        logic [7:0][15:0] p0;
        logic [7:0][15:0] p1;
        logic [3:0][31:0] e0;
        logic [3:0][31:0] e1;
    } job_t;

    job_t jobs [5];

    always #5 clk = ~clk;

    accum_scheduler #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_tiles(cfg_tiles),
        .cfg_results(cfg_results), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_col0(psum_col0), .psum_col1(psum_col1), .acc_enable(acc_enable),
        .acc_mode(acc_mode), .acc_buffer_select(acc_buffer_select),
        .acc_in_col0(acc_in_col0), .acc_in_col1(acc_in_col1),
        .acc_valid_out(acc_valid_out), .acc_out_col0(acc_out_col0),
        .acc_out_col1(acc_out_col1), .res_valid(res_valid), .res_ready(res_ready),
        .res_col0(res_col0), .res_col1(res_col1), .res_buf(res_buf), .busy(busy),
        .done(done), .err(err)
    );

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Accumulator memory: overwrite or add, result registered one cycle later.
    always @(posedge clk) begin
        if (reset) begin
            acc_valid_out <= 1'b0;
        end else begin
            acc_valid_out <= acc_enable && !kill_valid;
            if (acc_enable) begin
                mem0[acc_buffer_select] <= acc_mode ? mem0[acc_buffer_select] + sx(acc_in_col0)
                                                    : sx(acc_in_col0);
                mem1[acc_buffer_select] <= acc_mode ? mem1[acc_buffer_select] + sx(acc_in_col1)
                                                    : sx(acc_in_col1);
                acc_out_col0 <= acc_mode ? mem0[acc_buffer_select] + sx(acc_in_col0)
                                         : sx(acc_in_col0);
                acc_out_col1 <= acc_mode ? mem1[acc_buffer_select] + sx(acc_in_col1)
                                         : sx(acc_in_col1);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_psum_ready"}, psum_ready, 0);
        chk({tag, "_acc_enable"}, acc_enable, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_res_col0"}, res_col0, 0);
        chk({tag, "_res_col1"}, res_col1, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Runs one job; res_ready is held low for the first `hold` cycles.
    task automatic run_job(input job_t j, input int hold);
        int   te, pi, ri, cyc;
        int   last_cyc [4];
        logic x;
        te = (j.tiles == 0) ? 1 : int'(j.tiles);
        @(negedge clk);
        start = 1'b1; cfg_tiles = j.tiles; cfg_results = j.results;
        @(negedge clk);
        start = 1'b0;
        pi = 0; ri = 0; cyc = 0;
        while (ri < int'(j.results) && cyc < 200) begin
            res_ready  = (cyc >= hold);
            psum_valid = (pi < int'(j.n));
            psum_col0  = (pi < int'(j.n)) ? j.p0[pi[2:0]] : 16'h0;
            psum_col1  = (pi < int'(j.n)) ? j.p1[pi[2:0]] : 16'h0;
            #1;
            if (hold > 0 && cyc == hold) begin
                chk("bp_accepted", pi, 2);
                chk("bp_psum_ready", psum_ready, 0);
            end
            chk("busy_run", busy, 1);
            x = psum_valid && psum_ready;
            if (x) begin
                chk("acc_mode", acc_mode, ((pi % te) != 0));
                chk("acc_buffer_select", acc_buffer_select, (pi / te) % 2);
                chk("acc_in_col0", acc_in_col0, psum_col0);
                if ((pi % te) == te - 1) last_cyc[(pi / te) % 4] = cyc;
            end
            if (res_valid) begin
                chk("res_col0", res_col0, j.e0[ri[1:0]]);
                chk("res_col1", res_col1, j.e1[ri[1:0]]);
                chk("res_buf", res_buf, ri % 2);
                if (res_ready) begin
                    if (hold == 0) chk("res_latency", cyc - last_cyc[ri], 2);
                    ri++;
                end
            end
            @(negedge clk);
            if (x) pi++;
            cyc++;
        end
        psum_valid = 1'b0;
        #1;
        chk("result_count", ri, j.results);
        chk("psum_count", pi, j.n);
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
        @(negedge clk);
        #1;
        chk("done_low", done, 0);
    endtask

    initial begin
        jobs[0] = '0;
        jobs[0].tiles = 8'd3; jobs[0].results = 8'd1; jobs[0].n = 4'd3;
        jobs[0].p0[0] = 16'd1;    jobs[0].p1[0] = 16'd2;
        jobs[0].p0[1] = 16'd10;   jobs[0].p1[1] = 16'd20;
        jobs[0].p0[2] = 16'hFFFB; jobs[0].p1[2] = 16'hFF9C;
        jobs[0].e0[0] = 32'd6;    jobs[0].e1[0] = 32'hFFFFFFB2;

        jobs[1] = '0;
        jobs[1].tiles = 8'd0; jobs[1].results = 8'd2; jobs[1].n = 4'd2;
        jobs[1].p0[0] = 16'd7;    jobs[1].p1[0] = 16'd3;
        jobs[1].p0[1] = 16'hFFFF; jobs[1].p1[1] = 16'd5;
        jobs[1].e0[0] = 32'd7;    jobs[1].e1[0] = 32'd3;
        jobs[1].e0[1] = 32'hFFFFFFFF; jobs[1].e1[1] = 32'd5;

        jobs[2] = '0;
        jobs[2].tiles = 8'd2; jobs[2].results = 8'd3; jobs[2].n = 4'd6;
        jobs[2].p0[0] = 16'd100;  jobs[2].p1[0] = 16'hFFFF;
        jobs[2].p0[1] = 16'd200;  jobs[2].p1[1] = 16'hFFFE;
        jobs[2].p0[2] = 16'hFFCE; jobs[2].p1[2] = 16'd4;
        jobs[2].p0[3] = 16'd50;   jobs[2].p1[3] = 16'd4;
        jobs[2].p0[4] = 16'd1000; jobs[2].p1[4] = 16'd0;
        jobs[2].p0[5] = 16'hFC18; jobs[2].p1[5] = 16'd1;
        jobs[2].e0[0] = 32'd300;  jobs[2].e1[0] = 32'hFFFFFFFD;
        jobs[2].e0[1] = 32'd0;    jobs[2].e1[1] = 32'd8;
        jobs[2].e0[2] = 32'd0;    jobs[2].e1[2] = 32'd1;

        jobs[3] = '0;
        jobs[3].tiles = 8'd1; jobs[3].results = 8'd4; jobs[3].n = 4'd4;
        jobs[3].p0[0] = 16'd1; jobs[3].p1[0] = 16'hFFFF;
        jobs[3].p0[1] = 16'd2; jobs[3].p1[1] = 16'hFFFE;
        jobs[3].p0[2] = 16'd3; jobs[3].p1[2] = 16'hFFFD;
        jobs[3].p0[3] = 16'd4; jobs[3].p1[3] = 16'hFFFC;
        jobs[3].e0[0] = 32'd1; jobs[3].e1[0] = 32'hFFFFFFFF;
        jobs[3].e0[1] = 32'd2; jobs[3].e1[1] = 32'hFFFFFFFE;
        jobs[3].e0[2] = 32'd3; jobs[3].e1[2] = 32'hFFFFFFFD;
        jobs[3].e0[3] = 32'd4; jobs[3].e1[3] = 32'hFFFFFFFC;

        jobs[4] = '0;
        jobs[4].tiles = 8'd1; jobs[4].results = 8'd1; jobs[4].n = 4'd1;
        jobs[4].p0[0] = 16'd5; jobs[4].p1[0] = 16'hFFFB;
        jobs[4].e0[0] = 32'd5; jobs[4].e1[0] = 32'hFFFFFFFB;

        reset = 1'b1; start = 1'b0; psum_valid = 1'b0; res_ready = 1'b0;
        kill_valid = 1'b0; cfg_tiles = '0; cfg_results = '0;
        psum_col0 = '0; psum_col1 = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("init");
        reset = 1'b0;

        for (int k = 0; k < 4; k++) run_job(jobs[k], 0);
        chk("err_clean", err, 0);

        // Result backpressure: only two partial sums fit before the slots fill.
        run_job(jobs[3], 10);

        // Zero-result job goes straight to DONE.
        @(negedge clk);
        start = 1'b1; cfg_tiles = 8'd1; cfg_results = 8'd0; psum_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_psum_ready", psum_ready, 0);
        @(negedge clk);
        #1;
        chk("zero_done_low", done, 0);
        chk("zero_psum_ready2", psum_ready, 0);
        psum_valid = 1'b0;

        // Reset in the middle of a job, after one tile has been accepted.
        @(negedge clk);
        start = 1'b1; cfg_tiles = 8'd3; cfg_results = 8'd1;
        @(negedge clk);
        start = 1'b0; psum_valid = 1'b1; psum_col0 = 16'd9; psum_col1 = 16'd9;
        #1;
        chk("mid_psum_ready", psum_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_outputs("midreset");
        reset = 1'b0; psum_valid = 1'b0;
        run_job(jobs[0], 0);

        // Accumulator output never valid: error latches and stays.
        kill_valid = 1'b1;
        run_job(jobs[4], 0);
        chk("err_set", err, 1);
        kill_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("err_sticky", err, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("err_cleared", err, 0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/accum_scheduler.md
ACCUM_SCHEDULER -- requirements
Module: accum_scheduler

Interface
REQ-001 Parameter CNT_W, default 8: width of the tile and result counters and config ports.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  job start pulse; sampled only in IDLE.
REQ-005 cfg_tiles  in  CNT_W  partial sums per result; 0 treated as 1; latched at start.
REQ-006 cfg_results  in  CNT_W  results per job; latched at start.
REQ-007 psum_valid / psum_ready  in / out  1 each  upstream partial-sum handshake; transfer = both high.
REQ-008 psum_col0, psum_col1  in  16 each  signed partial sums.
REQ-009 acc_enable, acc_mode, acc_buffer_select  out  1 each  accumulator-memory controls.
REQ-010 acc_in_col0, acc_in_col1  out  16 each  combinational pass-through of psum_col0/1.
REQ-011 acc_valid_out  in  1; acc_out_col0, acc_out_col1  in  32 each  accumulator-memory outputs, valid one cycle after acc_enable.
REQ-012 res_valid / res_ready  out / in  1 each  downstream result handshake.
REQ-013 res_col0, res_col1  out  32 each  completed results; res_buf  out  1  slot index of presented result.
REQ-014 busy  out  1  high in RUN and DRAIN; done  out  1  one-cycle pulse at job end; err  out  1  sticky protocol error.

Function
REQ-015 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with cfg_results!=0; IDLE->DONE on start with cfg_results==0; start outside IDLE ignored.
REQ-016 psum_ready = state==RUN and slot[fill_buf] neither full nor pending; otherwise 0.
REQ-017 acc_enable = psum_valid & psum_ready (combinational); acc_buffer_select = fill_buf; acc_mode = (tile_cnt != 0): first tile overwrites, later tiles add.
REQ-018 Each transfer increments tile_cnt; transfer with tile_cnt == tiles-1 is "last": tile_cnt->0, pending[fill_buf] set, fill_buf toggles, issued_cnt increments, all at that edge.
REQ-019 Cycle after a last transfer: pending slot captures acc_out_col0/1 into its 32-bit holding register, full set, pending cleared; res_valid can rise the following cycle (2 cycles after last transfer).
REQ-020 If pending and acc_valid_out==0 in the capture cycle, err SHALL set (sticky until reset); capture still occurs.
REQ-021 Two result slots read in order via rd_ptr (starts 0); res_valid = full[rd_ptr]; res_col0/1, res_buf from slot rd_ptr; res_valid&res_ready clears full[rd_ptr], toggles rd_ptr, increments drained_cnt.
REQ-022 res_col0/1 hold stable while res_valid && !res_ready.
REQ-023 Capture into one slot and drain of the other in the same cycle both take effect.
REQ-024 RUN->DRAIN on the edge where issued_cnt reaches cfg_results; no further psum acceptance.
REQ-025 DRAIN->DONE when drained_cnt reaches cfg_results (including the drain in that cycle); DONE->IDLE after one cycle; done high only in DONE.
REQ-026 Each start resets fill_buf, rd_ptr, tile_cnt, issued_cnt, drained_cnt to 0; slots empty (guaranteed by prior job completion).
REQ-027 All arithmetic unsigned on counters; no wrap: cfg_results up to 2^CNT_W-1 supported, counters CNT_W bits.

Reset
REQ-028 reset SHALL force: state IDLE, all counters 0, fill_buf 0, rd_ptr 0, full/pending 0, holding registers 0, err 0.
REQ-029 During/after reset outputs: psum_ready 0, acc_enable 0, res_valid 0, busy 0, done 0, res_col0/1 0.
REQ-030 reset mid-job abandons the job immediately; in-flight acc_valid_out the next cycle is ignored.

Verification
REQ-031 cfg_tiles=3, cfg_results=1, psums (1,2),(10,20),(-5,-100) back-to-back, res_ready=1 -> acc_mode 0,1,1; acc_buffer_select 0; res_col0=6, res_col1=-78, res_buf 0, res_valid 2 cycles after third transfer; done pulse next.
REQ-032 cfg_tiles=1, cfg_results=4, res_ready=0 -> exactly 2 psums accepted (buffers 0,1), psum_ready then 0; raise res_ready -> remaining 2 accepted, 4 results in order with res_buf 0,1,0,1.
REQ-033 cfg_tiles=0, cfg_results=2, psums 7 and -1 -> treated as 1 tile, acc_mode 0 both, results 7 and 0xFFFFFFFF.
REQ-034 start with cfg_results=0 -> busy stays 0, done pulses 1 cycle after start, psum_ready never rises.
REQ-035 Reset asserted during RUN with tile_cnt=1 -> next cycle all outputs at reset values; new job after reset produces correct sums, acc_mode 0 on first psum.
REQ-036 Last transfer with acc_valid_out tied 0 -> err=1 and remains 1 until reset.
